// File: rtl/mlp_seq_pkg.sv
// Shared types and default constants for the MLP feature sequencer.
// Holds the sequencer state enum and the classifier's default frame geometry.
package mlp_seq_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_OUTPUT  = 2'd2
    } seq_state_e;

    localparam int N_FEAT  = 11;
    localparam int FEAT_W  = 4;
    localparam int CLS_W   = 3;
    localparam int N_CLASS = 6;

endpackage

// File: rtl/mlp_feature_sequencer_packer.sv
// Feature packer: slot register file plus write index for one feature frame.
// Each write lands in slot idx; clear returns idx to 0 without touching slots.
module feature_packer #(
    parameter int N_FEAT = mlp_seq_pkg::N_FEAT,
    parameter int FEAT_W = mlp_seq_pkg::FEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic                     clr_i,
    input  logic [FEAT_W-1:0]        data_i,
    output logic [N_FEAT*FEAT_W-1:0] feat_o,
    output logic                     full_o
);
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;

    always_comb begin
        feat_d = feat_q;
        idx_d  = idx_q;
        if (we_i) begin
            for (int k = 0; k < N_FEAT; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    feat_d[k*FEAT_W +: FEAT_W] = data_i;
                end
            end
        end
        // Clear wins over increment so the frame-closing write restarts at slot 0.
        if (clr_i) begin
            idx_d = '0;
        end else if (we_i) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            feat_q <= '0;
        end else begin
            idx_q  <= idx_d;
            feat_q <= feat_d;
        end
    end

    assign feat_o = feat_q;
    assign full_o = (idx_q == IDX_W'(N_FEAT - 1));

endmodule

// File: rtl/mlp_feature_sequencer.sv
// Stream front end for the MLP classifier core: packs features, holds the vector
// while the core settles, captures the class and offers it on a result port.
module mlp_feature_sequencer #(
    parameter int N_FEAT  = mlp_seq_pkg::N_FEAT,
    parameter int FEAT_W  = mlp_seq_pkg::FEAT_W,
    parameter int CLS_W   = mlp_seq_pkg::CLS_W,
    parameter int N_CLASS = mlp_seq_pkg::N_CLASS,
    parameter int SETTLE  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_o,
    input  logic [CLS_W-1:0]         cls_i,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     m_oob,
    output logic                     err_o,
    output logic [15:0]              frame_cnt,
    output logic [1:0]               dbg_state_o
);
    import mlp_seq_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never looks at valid and valid never looks at ready.

    seq_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_q;
    logic             err_q, err_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic             oob_q, oob_d;
    logic [15:0]      fcnt_q, fcnt_d;

    logic s_hs;
    logic wr_en;
    logic pk_clr;
    logic pk_full;

    assign s_hs = s_valid & ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        cls_d   = cls_q;
        oob_d   = oob_q;
        fcnt_d  = fcnt_q;
        wr_en   = 1'b0;
        pk_clr  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (s_hs) begin
                    wr_en  = 1'b1;
                    pk_clr = pk_full | s_last;
                    if (pk_full && s_last) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 4'd0;
                    end else if (pk_full || s_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE - 1)) begin
                    cls_d   = cls_i;
                    oob_d   = (int'(cls_i) >= N_CLASS);
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (m_ready) begin
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // ready is registered so it stays low for the whole reset and comes up one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cls_q   <= '0;
            oob_q   <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_COLLECT);
            err_q   <= err_d;
            cls_q   <= cls_d;
            oob_q   <= oob_d;
            fcnt_q  <= fcnt_d;
        end
    end

    feature_packer #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .we_i   (wr_en),
        .clr_i  (pk_clr),
        .data_i (s_data),
        .feat_o (feat_o),
        .full_o (pk_full)
    );

    assign s_ready     = ready_q;
    assign m_valid     = (state_q == ST_OUTPUT);
    assign m_class     = cls_q;
    assign m_oob       = oob_q;
    assign err_o       = err_q;
    assign frame_cnt   = fcnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Self-checking bench for mlp_feature_sequencer with a stub classifier core.
// A frame-level reference model is compared against the DUT every cycle.
module tb_mlp_feature_sequencer;
    localparam int N_FEAT  = 11;
    localparam int FEAT_W  = 4;
    localparam int CLS_W   = 3;
    localparam int N_CLASS = 6;
    localparam int SETTLE  = 2;
    localparam int VW      = N_FEAT * FEAT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic [FEAT_W-1:0] s_data = '0;
    logic              m_ready = 1'b0;
    logic [CLS_W-1:0]  cls_i;
    logic              s_ready, m_valid, m_oob, err_o;
    logic [VW-1:0]     feat_o;
    logic [CLS_W-1:0]  m_class;
    logic [15:0]       frame_cnt;
    logic [1:0]        dbg_state;

    logic              force_en = 1'b0;
    logic [CLS_W-1:0]  force_val = '0;
    bit                rand_mr = 1'b0;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int mv_seen = 0;

    always #5 clk = ~clk;

    mlp_feature_sequencer #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .N_CLASS(N_CLASS), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .feat_o(feat_o), .cls_i(cls_i), .m_valid(m_valid),
        .m_ready(m_ready), .m_class(m_class), .m_oob(m_oob), .err_o(err_o),
        .frame_cnt(frame_cnt), .dbg_state_o(dbg_state)
    );

    // Stub core: all-zero vector classifies as 2, otherwise feature sum mod 8.
    function automatic logic [CLS_W-1:0] core_stub(input logic [VW-1:0] f);
        int s;
        if (f == '0) return 3'd2;
        s = 0;
        for (int k = 0; k < N_FEAT; k++) s += int'(f[k*FEAT_W +: FEAT_W]);
        return 3'(s);
    endfunction

    assign cls_i = force_en ? force_val : core_stub(feat_o);

    // ---------------- reference model ----------------
    bit               started = 1'b0;
    bit               mdl_ready = 1'b0;
    logic [FEAT_W-1:0] mdl_feat [N_FEAT];
    int               mdl_n = 0;
    int               mdl_wait = 0;
    bit               mdl_out = 1'b0;
    bit               mdl_err = 1'b0;
    logic [CLS_W-1:0] mdl_cls = '0;
    bit               mdl_oob = 1'b0;
    logic [15:0]      mdl_cnt = '0;
    logic [CLS_W-1:0] exp_q[$];

    function automatic logic [VW-1:0] mdl_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N_FEAT; k++) v[k*FEAT_W +: FEAT_W] = mdl_feat[k];
        return v;
    endfunction

    initial for (int k = 0; k < N_FEAT; k++) mdl_feat[k] = '0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            mdl_ready = 1'b0;
            for (int k = 0; k < N_FEAT; k++) mdl_feat[k] = '0;
            mdl_n = 0; mdl_wait = 0; mdl_out = 1'b0; mdl_err = 1'b0;
            mdl_cls = '0; mdl_oob = 1'b0; mdl_cnt = '0;
            exp_q.delete();
        end else begin
            mdl_err = 1'b0;
            if (mdl_out) begin
                if (m_ready) begin
                    mdl_out = 1'b0;
                    mdl_cnt = mdl_cnt + 16'd1;
                    mdl_ready = 1'b1;
                end
            end else if (mdl_wait > 0) begin
                mdl_wait--;
                if (mdl_wait == 0) begin
                    mdl_cls = exp_q.pop_front();
                    mdl_oob = (int'(mdl_cls) >= N_CLASS);
                    mdl_out = 1'b1;
                end
            end else begin
                if (s_valid && mdl_ready) begin
                    mdl_feat[mdl_n] = s_data;
                    if (s_last && mdl_n == N_FEAT - 1) begin
                        exp_q.push_back(force_en ? force_val : core_stub(mdl_vec()));
                        mdl_n = 0;
                        mdl_wait = SETTLE;
                    end else if (s_last || mdl_n == N_FEAT - 1) begin
                        mdl_err = 1'b1;
                        mdl_n = 0;
                    end else begin
                        mdl_n++;
                    end
                end
                mdl_ready = (mdl_wait == 0);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("s_ready",   64'(s_ready),   64'(mdl_ready));
            check("m_valid",   64'(m_valid),   64'(mdl_out));
            check("err_o",     64'(err_o),     64'(mdl_err));
            check("frame_cnt", 64'(frame_cnt), 64'(mdl_cnt));
            check("feat_o",    64'(feat_o),    64'(mdl_vec()));
            check("m_class",   64'(m_class),   64'(mdl_cls));
            check("m_oob",     64'(m_oob),     64'(mdl_oob));
            if (err_o === 1'b1) err_seen++;
            if (m_valid === 1'b1) mv_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
        if (rand_mr) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [FEAT_W-1:0] d, input logic l, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) step();
        s_valid = 1'b1; s_data = d; s_last = l;
        t = 0;
        while (s_ready !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no s_ready expected s_ready within 100 cycles");
        end
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input logic [VW-1:0] v, input int n, input int last_at, input int maxgap);
        for (int k = 0; k < n; k++)
            send(v[k*FEAT_W +: FEAT_W], (k == last_at), $urandom_range(0, maxgap));
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (m_valid !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL result_timeout: got no m_valid expected m_valid within 50 cycles");
        end
    endtask

    task automatic accept();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N_FEAT; k++) v[k*FEAT_W +: FEAT_W] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] held_feat;
        logic [CLS_W-1:0] held_cls;
        logic [CLS_W-1:0] fvals [3];
        int e0, mv0, kind, pos;

        // Reset with random inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 4'($urandom_range(0, 15));
            s_last  = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_feat",    64'(feat_o),  64'd0);
        check("rst_cnt",     64'(frame_cnt), 64'd0);
        check("rst_err",     64'(err_o),   64'd0);
        #1;
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(s_ready), 64'd1);
        #1;

        // Golden all-zero frame
        send_frame('0, N_FEAT, N_FEAT - 1, 0);
        wait_result();
        check("golden_class", 64'(m_class), 64'd2);
        check("golden_oob",   64'(m_oob),   64'd0);
        accept();
        check("golden_cnt", 64'(frame_cnt), 64'd1);

        // Packing k = k and result latency
        for (int k = 0; k < N_FEAT; k++) v[k*FEAT_W +: FEAT_W] = 4'(k);
        send_frame(v, N_FEAT, N_FEAT - 1, 0);
        check("pack_vec", 64'(feat_o), 64'hA9876543210);
        repeat (SETTLE - 1) step();
        check("latency_early", 64'(m_valid), 64'd0);
        step();
        check("latency_on", 64'(m_valid), 64'd1);
        check("pack_class", 64'(m_class), 64'd7);

        // Backpressure with s_valid held high
        held_feat = feat_o;
        held_cls  = m_class;
        s_valid = 1'b1; s_data = 4'hF; s_last = 1'b0;
        repeat (5) begin
            step();
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_s_ready", 64'(s_ready), 64'd0);
            check("bp_feat",    64'(feat_o),  64'(held_feat));
            check("bp_class",   64'(m_class), 64'(held_cls));
        end
        s_valid = 1'b0;
        accept();
        check("bp_cnt", 64'(frame_cnt), 64'd2);

        // Early last on feature 4, then a good frame
        e0 = err_seen; mv0 = mv_seen;
        send_frame(rand_vec(), 5, 4, 0);
        repeat (4) step();
        check("early_err_pulses", 64'(err_seen - e0), 64'd1);
        check("early_no_valid",   64'(mv_seen - mv0), 64'd0);
        send_frame(rand_vec(), N_FEAT, N_FEAT - 1, 1);
        wait_result();
        accept();

        // Missing last, then a good frame
        e0 = err_seen; mv0 = mv_seen;
        send_frame(rand_vec(), N_FEAT, -1, 0);
        repeat (4) step();
        check("miss_err_pulses", 64'(err_seen - e0), 64'd1);
        check("miss_no_valid",   64'(mv_seen - mv0), 64'd0);
        send_frame(rand_vec(), N_FEAT, N_FEAT - 1, 1);
        wait_result();
        accept();

        // Reset mid-SETTLE
        send_frame(rand_vec(), N_FEAT, N_FEAT - 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mv0 = mv_seen;
        repeat (6) step();
        check("rst_settle_no_valid", 64'(mv_seen - mv0), 64'd0);
        check("rst_settle_cnt",      64'(frame_cnt),     64'd0);
        send(4'h3, 1'b0, 0);
        send(4'h5, 1'b0, 0);
        send(4'h9, 1'b0, 0);
        check("idx_restart", 64'(feat_o), 64'h953);
        for (int k = 3; k < N_FEAT; k++) send(4'(k), (k == N_FEAT - 1), 0);
        wait_result();
        accept();

        // Forced class indices around the out-of-range boundary
        fvals[0] = 3'd5; fvals[1] = 3'd6; fvals[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            force_en = 1'b1; force_val = fvals[i];
            send_frame(rand_vec(), N_FEAT, N_FEAT - 1, 0);
            wait_result();
            check("forced_class", 64'(m_class), 64'(fvals[i]));
            check("forced_oob",   64'(m_oob),   (i == 0) ? 64'd0 : 64'd1);
            accept();
        end
        force_en = 1'b0;

        // Random traffic with framing mistakes and random m_ready
        rand_mr = 1'b1;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                pos = $urandom_range(0, N_FEAT - 2);
                send_frame(rand_vec(), pos + 1, pos, 2);
            end else if (kind == 1) begin
                send_frame(rand_vec(), N_FEAT, -1, 2);
            end else begin
                send_frame(rand_vec(), N_FEAT, N_FEAT - 1, 2);
            end
        end
        rand_mr = 1'b0;
        m_ready = 1'b1;
        repeat (20) step();
        m_ready = 1'b0;
        check("drain_no_pending", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mlp_feature_sequencer.md
# mlp_feature_sequencer

Stream-side front end for the printed red-wine MLP classifier core. It accepts eleven 4-bit quantised features one per handshake from an upstream sensor/ADC stream and packs them into the core's 44-bit feature vector. It holds that vector stable while the combinational core settles, then captures the 3-bit class index and returns it on a valid/ready result port. The block sits between the feature stream and the classifier core; the core itself is instantiated alongside, not inside, this block.

## Interface
- `N_FEAT`, default 11: features per frame.
- `FEAT_W`, default 4: bits per feature.
- `CLS_W`, default 3: class index width.
- `N_CLASS`, default 6: legal class count; indices `>= N_CLASS` are out of range.
- `SETTLE`, default 2: cycles the vector is held before capture. Legal range is 1..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  feature nibble valid.
- `s_ready`  out  1  block accepts a nibble.
- `s_data`  in  FEAT_W  feature value, unsigned.
- `s_last`  in  1  marks the final feature of a frame.
- `feat_o`  out  N_FEAT*FEAT_W  packed vector to the core; feature k occupies bits [k*FEAT_W +: FEAT_W].
- `cls_i`  in  CLS_W  class index from the core.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts result.
- `m_class`  out  CLS_W  captured class.
- `m_oob`  out  1  captured class is `>= N_CLASS`.
- `err_o`  out  1  one-cycle pulse on a framing error.
- `frame_cnt`  out  16  completed classifications; wraps 0xFFFF -> 0.

## Operation
- FSM states are COLLECT, SETTLE and OUTPUT. Reset state is COLLECT with slot index `idx` = 0.
- **COLLECT**
  - `s_ready` = 1.
  - On `s_valid & s_ready`, `s_data` is written to slot `idx` of `feat_o`; other slots are unchanged.
  - If `idx < N_FEAT-1` and `s_last` = 0: `idx` increments.
  - If `idx < N_FEAT-1` and `s_last` = 1: early-last framing error. `err_o` pulses, `idx` <- 0, the FSM stays in COLLECT, and the partial data is discarded.
  - If `idx == N_FEAT-1` and `s_last` = 1: `idx` <- 0, settle counter <- 0, go to SETTLE.
  - If `idx == N_FEAT-1` and `s_last` = 0: missing-last framing error. `err_o` pulses, `idx` <- 0, the FSM stays in COLLECT, and there is no classification.
- **SETTLE**
  - `s_ready` = 0 and `feat_o` is frozen.
  - The counter increments each cycle.
  - On the cycle where the counter reaches SETTLE-1, capture `cls_i` into `m_class`, compute `m_oob` = (`cls_i >= N_CLASS`), and go to OUTPUT.
- **OUTPUT**
  - `m_valid` = 1, `s_ready` = 0, and `m_class`, `m_oob`, `feat_o` are held.
  - On `m_valid & m_ready`: `frame_cnt` increments and the FSM returns to COLLECT.
- `feat_o` changes only in COLLECT. After an error, stale slot values remain until overwritten, and the core output is ignored.
- Feature bits are never modified or rescaled; the block only packs and captures.

## Timing
- **Reset values:** `s_ready`=0 while `rst` is high and 1 from the first cycle after release; `feat_o`=0, `m_valid`=0, `m_class`=0, `m_oob`=0, `err_o`=0, `frame_cnt`=0.
- **Result latency:** the last nibble is accepted at edge T. `m_valid` rises after edge T+SETTLE.
- **Minimum frame period:** N_FEAT + SETTLE + 1 cycles, which is 14 at the defaults.
- `err_o` is registered and asserted for exactly the cycle after the offending handshake.
- `s_ready` depends only on state, never on `s_valid`. `m_valid` does not depend on `m_ready`.
- `rst` asserted in any state returns all outputs to their reset values at that edge. An in-flight frame or result is lost and `frame_cnt` clears.
- `cls_i` is sampled only at the capture edge. Changes on `cls_i` at other times have no effect.

## Structure
- Shared package `mlp_seq_pkg` holds:
  - the state enum (COLLECT/SETTLE/OUTPUT);
  - the default constants N_FEAT, FEAT_W, CLS_W, N_CLASS.
- The feature packer (slot register plus `idx` counter) is the natural sub-module, `feature_packer`, with write enable, clear, and `full` indication.
- The settle counter and result register stay in the top level.

## Test plan
- **Reset:** hold `rst` 3 cycles with random inputs. All outputs are at reset values, and `s_ready`=1 the cycle after release.
- **Packing:** send feature k = k for k = 0..10, with `s_last` on k=10. Expect `feat_o` = 44'hA9876543210, and `m_valid` high exactly SETTLE cycles after the last handshake.
- **Golden class:** send an all-zero frame with the core attached. Expect `m_class`=2, `m_oob`=0, and `frame_cnt` incrementing to 1 on `m_ready`.
- **Backpressure:** hold `m_ready`=0 for 5 cycles with `s_valid`=1. Expect `m_valid`, `m_class`, `feat_o` stable, `s_ready`=0, and no nibbles consumed.
- **Framing errors:**
  - `s_last` on feature 4: `err_o` pulses once and there is no `m_valid`.
  - 11th nibble with `s_last`=0: `err_o` pulses and there is no `m_valid`.
  - After each error, a following correct frame classifies normally.
- **Reset and out-of-range:**
  - `rst` mid-SETTLE: `m_valid` never asserts and `idx` restarts at 0.
  - Forced `cls_i`=7: `m_oob`=1, `m_class`=7.
  - After 65536 frames: `frame_cnt` wraps to 0.
